// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the queued command record.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // One queued ALU command; chain selects the accumulator as operand A.
  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       chain;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH entries, wrapping pointers, occupancy counter.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  alu_cmd_t      wr_cmd,
  output alu_cmd_t      head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  alu_cmd_t      mem [DEPTH];
  logic [PW-1:0] wptr, rptr;

  assign head  = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Storage needs no reset: the head is masked by empty downstream.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_cmd;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_queue.sv
// Queues ALU commands, dispatches the head to an external ALU and
// registers its result; supports chaining on the last retired result.
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [7:0]    in_a,
  input  logic [7:0]    in_b,
  input  logic          in_chain,
  output logic [2:0]    alu_op,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  input  logic [7:0]    alu_result,
  input  logic          alu_zero,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_result,
  output logic          out_zero,
  output logic [2:0]    out_op,
  output logic [CW-1:0] count
);

  alu_cmd_t   wr_cmd, head;
  logic       empty, full, push, capture;
  logic [7:0] acc;

  assign wr_cmd   = '{op: in_op, a: in_a, b: in_b, chain: in_chain};
  // Full refuses a push even when a pop lands in the same cycle.
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign capture  = !empty && (!out_valid || out_ready);

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (capture),
    .wr_cmd (wr_cmd),
    .head   (head),
    .count  (count),
    .empty  (empty),
    .full   (full)
  );

  // Drive the ALU from the FIFO head; quiet zeros when nothing is queued.
  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (!empty) begin
      alu_op = head.op;
      alu_a  = head.chain ? acc : head.a;
      alu_b  = head.b;
    end
  end

  // Output register and accumulator; both move only on capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_op     <= '0;
      acc        <= '0;
    end else if (capture) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_zero   <= alu_zero;
      out_op     <= head.op;
      acc        <= alu_result;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue with a behavioural ALU attached.
module tb_alu_cmd_queue;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_chain;
  logic [2:0] in_op, alu_op, out_op;
  logic [7:0] in_a, in_b, alu_a, alu_b, alu_result, out_result;
  logic       alu_zero, out_valid, out_ready, out_zero;
  logic [2:0] count;

  int checks = 0;
  int failures = 0;

  alu_cmd_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_chain(in_chain),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_op(out_op),
    .count(count)
  );

  always #5 clk = ~clk;

  // External ALU model
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_NOT:  alu_result = ~alu_a;
      OP_SHL:  alu_result = alu_a << 1;
      default: alu_result = alu_a >> 1;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic ch);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_chain = ch;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_chain = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1; idle();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if ({out_result, out_zero, out_op, alu_a} !== 20'h0) begin failures++;
      $display("FAIL reset_data got res=%h z=%b op=%h alu_a=%h exp=0", out_result, out_zero, out_op, alu_a); end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive(OP_ADD, 8'h05, 8'h03, 1'b0);
    tick();
    idle();
    tick();
    checks++; if (out_valid !== 1'b1 || out_result !== 8'h08 || out_zero !== 1'b0 || out_op !== OP_ADD) begin failures++;
      $display("FAIL add_result got v=%b res=%h z=%b op=%h exp v=1 res=08 z=0 op=0", out_valid, out_result, out_zero, out_op); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_result !== 8'h08) begin failures++;
      $display("FAIL add_drain got v=%b res=%h exp v=0 res=08", out_valid, out_result); end
  endtask

  task automatic test_wrap_zero();
    out_ready = 1'b1;
    drive(OP_ADD, 8'hFF, 8'h01, 1'b0);
    tick();
    idle();
    tick();
    checks++; if (out_valid !== 1'b1 || out_result !== 8'h00 || out_zero !== 1'b1) begin failures++;
      $display("FAIL wrap_zero got v=%b res=%h z=%b exp v=1 res=00 z=1", out_valid, out_result, out_zero); end
    tick();
  endtask

  task automatic test_full_backpressure();
    logic [2:0] ops [5];
    logic [7:0] as [5];
    logic [7:0] bs [5];
    logic [7:0] exp [5];
    int idx;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    as  = '{8'h01, 8'h09, 8'hF0, 8'h01, 8'hFF};
    bs  = '{8'h01, 8'h04, 8'h3C, 8'h80, 8'h0F};
    exp = '{8'h02, 8'h05, 8'h30, 8'h81, 8'hF0};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], as[i], bs[i], 1'b0);
      tick();
    end
    drive(OP_ADD, 8'h10, 8'h10, 1'b0);
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin failures++;
      $display("FAIL full_state got count=%0d in_ready=%b exp count=4 in_ready=0", count, in_ready); end
    checks++; if (out_valid !== 1'b1 || out_result !== exp[0]) begin failures++;
      $display("FAIL full_head_held got v=%b res=%h exp v=1 res=%h", out_valid, out_result, exp[0]); end
    tick();
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_refuse got count=%0d exp=4", count); end
    out_ready = 1'b1;
    tick();
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL full_pop_refuse got count=%0d exp=3", count); end
    idle();
    idx = 1;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) begin
        checks++;
        if (idx > 4) begin failures++; $display("FAIL full_extra got res=%h exp none", out_result); end
        else if (out_result !== exp[idx]) begin failures++;
          $display("FAIL full_order[%0d] got=%h exp=%h", idx, out_result, exp[idx]); end
        idx++;
      end
      tick();
    end
    checks++; if (idx !== 5) begin failures++; $display("FAIL full_count_results got=%0d exp=5", idx); end
  endtask

  task automatic test_chain();
    out_ready = 1'b1;
    drive(OP_ADD, 8'h01, 8'h01, 1'b0);
    tick();
    drive(OP_ADD, 8'h77, 8'h03, 1'b1);
    tick();
    idle();
    checks++; if (out_result !== 8'h02 || alu_a !== 8'h02) begin failures++;
      $display("FAIL chain_first got res=%h alu_a=%h exp res=02 alu_a=02", out_result, alu_a); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_result !== 8'h05) begin failures++;
      $display("FAIL chain_second got v=%b res=%h exp v=1 res=05", out_valid, out_result); end
    tick();
  endtask

  task automatic test_back_to_back();
    int got, first, last;
    logic bad;
    got = 0; first = -1; last = -1; bad = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 6) begin
        if (!in_ready) bad = 1'b1;
        drive(OP_ADD, 8'(c), 8'h01, 1'b0);
      end else idle();
      tick();
      if (out_valid) begin
        if (out_result !== 8'(got + 1)) bad = 1'b1;
        if (first < 0) first = c;
        last = c;
        got++;
      end
    end
    checks++; if (bad || got != 6 || (last - first) != 5) begin failures++;
      $display("FAIL back_to_back got n=%0d span=%0d bad=%b exp n=6 span=5 bad=0", got, last - first, bad); end
  endtask

  task automatic test_reset_mid();
    int stale;
    stale = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(OP_OR, 8'(i + 1), 8'h40, 1'b0);
      tick();
    end
    idle();
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++;
      $display("FAIL midreset_clear got count=%0d v=%b exp count=0 v=0", count, out_valid); end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_valid) stale++;
    end
    checks++; if (stale != 0 || in_ready !== 1'b1) begin failures++;
      $display("FAIL midreset_stale got pulses=%0d in_ready=%b exp pulses=0 in_ready=1", stale, in_ready); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_wrap_zero();
    test_full_backpressure();
    test_chain();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_queue.md
ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of command FIFO entries; power of two, 2..16.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  command offered.
REQ-005 in_ready  output  1  command FIFO can accept.
REQ-006 in_op  input  3  ALU opcode.
REQ-007 in_a  input  8  operand A.
REQ-008 in_b  input  8  operand B.
REQ-009 in_chain  input  1  replace operand A with last retired result.
REQ-010 alu_op  output  3  opcode to downstream ALU.
REQ-011 alu_a  output  8  operand A to ALU.
REQ-012 alu_b  output  8  operand B to ALU.
REQ-013 alu_result  input  8  ALU result, combinational from alu_*.
REQ-014 alu_zero  input  1  ALU zero flag.
REQ-015 out_valid  output  1  registered result available.
REQ-016 out_ready  input  1  consumer accepts result.
REQ-017 out_result  output  8  registered result.
REQ-018 out_zero  output  1  registered zero flag.
REQ-019 out_op  output  3  opcode of registered result.
REQ-020 count  output  $clog2(DEPTH+1)  FIFO occupancy, excluding output register.

Function
REQ-021 Push when in_valid && in_ready; stores {op, a, b, chain} at write pointer.
REQ-022 in_ready SHALL be (count < DEPTH) from registered state; when full, push is refused even if a pop occurs in the same cycle.
REQ-023 alu_op/alu_b SHALL equal FIFO head fields; alu_a SHALL be head.chain ? acc : head.a; all zero when FIFO empty.
REQ-024 Capture when count != 0 && (!out_valid || out_ready): out_result <= alu_result, out_zero <= alu_zero, out_op <= head.op, acc <= alu_result, out_valid <= 1, FIFO pops.
REQ-025 When out_valid && out_ready and no capture, out_valid <= 0; out_* data hold.
REQ-026 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-027 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-028 Latency: command accepted in cycle N with FIFO empty and output free SHALL appear with out_valid in cycle N+1.
REQ-029 acc SHALL update only on capture; a chained command uses acc as of its own dispatch cycle, i.e. the previous command's result.
REQ-030 Throughput: one command per cycle sustained when out_ready held high.
REQ-031 Arithmetic and width: performed by ALU only; block does no width extension; results are 8-bit modulo 256.

Reset
REQ-032 On rst_n low: count, pointers, acc, out_result, out_zero, out_op = 0; out_valid = 0; in_ready = 1 after release.
REQ-033 Reset mid-operation SHALL discard all queued and registered commands; no out_valid pulse after release until a new push.

Structure
REQ-034 Package alu_pkg SHALL hold opcode constants (ADD=000, SUB=001, AND=010, OR=011, XOR=100, NOT=101, SHL=110, SHR=111) and the command struct typedef {op, a, b, chain}.
REQ-035 FIFO storage and pointers SHALL be sub-module alu_cmd_fifo; the ALU is instantiated outside this block.

Verification
REQ-036 Push ADD a=8'h05 b=8'h03, out_ready=1 -> next cycle out_valid=1, out_result=8'h08, out_zero=0, out_op=000.
REQ-037 Push ADD a=8'hFF b=8'h01 -> out_result=8'h00, out_zero=1 (wrap-around).
REQ-038 out_ready=0, push 5 commands -> first held in output register, count=4, in_ready=0; 6th in_valid not accepted; release out_ready -> 5 results in order.
REQ-039 Push ADD 8'h01+8'h01, then chained ADD b=8'h03 -> results 8'h02 then 8'h05.
REQ-040 Push 3 commands, out_ready=0, assert rst_n=0 for 1 cycle -> count=0, out_valid=0, no stale results after release.
